io_sequencer: RTL and testbench

Controller that sequences processor I/O requests onto the board's switches, confirm pushbutton and seven-segment output path. It accepts one request at a time from the core and stalls the core while the request is in progress. Input requests wait for a debounced press/release of the confirm key and capture the 18 switches. Output requests load the display driver and hold for a minimum time. It replaces ad-hoc edge-triggered Confirm handling with a single-clock, fully synchronous handshake.

---
 rtl/io_sequencer_if.sv | 23 ++
 rtl/io_sequencer.sv | 100 ++++++++++
 tb/tb_io_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/io_sequencer_if.sv
// Core-side I/O request bus plus the board's confirm key, switches and display path.
interface io_sequencer_if;
  logic        Req;
  logic        Req_Dir;
  logic [31:0] Req_Data;
  logic        Confirm_Raw;
  logic [17:0] Switches;
  logic [31:0] Rsp_Data;
  logic [31:0] Out_Data;
  logic        Out_Valid;
  logic        Stall;
  logic        Done;
  logic [7:0]  Input_Count;

  modport master (
    output Req, Req_Dir, Req_Data, Confirm_Raw, Switches,
    input  Rsp_Data, Out_Data, Out_Valid, Stall, Done, Input_Count
  );
  modport slave (
    input  Req, Req_Dir, Req_Data, Confirm_Raw, Switches,
    output Rsp_Data, Out_Data, Out_Valid, Stall, Done, Input_Count
  );
endinterface

// File: rtl/io_sequencer.sv
// Sequences one core I/O request at a time: switch reads gated by a debounced
// confirm press/release, display writes held for a minimum number of cycles.
module io_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int OUT_HOLD_CYCLES = 2
) (
  input  logic           Clock,
  input  logic           Reset,
  io_sequencer_if.slave  bus
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(OUT_HOLD_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, IN_WAIT_PRESS, IN_WAIT_RELEASE, OUT_HOLD, DONE
  } state_e;

  state_e          state_q;
  logic            sync1_q, sync2_q;
  logic            deb_q, deb_d;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
  logic [HW-1:0]   hold_q;
  logic [31:0]     rsp_q, out_q;
  logic            outv_q;
  logic [7:0]      cnt_q;
  logic            deb_flip, press, release_ev;

  // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample;
  // the press/release strobes line up with that same edge.
  assign deb_flip   = (sync2_q != deb_q) && (deb_cnt_q == DW'(DEBOUNCE_CYCLES - 1));
  assign press      = deb_flip &  deb_q;
  assign release_ev = deb_flip & ~deb_q;

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (deb_flip) deb_d = sync2_q;
    else if (sync2_q != deb_q) deb_cnt_d = deb_cnt_q + DW'(1);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      deb_q     <= 1'b1;
      deb_cnt_q <= '0;
      hold_q    <= '0;
      rsp_q     <= '0;
      out_q     <= '0;
      outv_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= bus.Confirm_Raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      outv_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.Req) begin
            if (bus.Req_Dir) begin
              state_q <= OUT_HOLD;
              hold_q  <= '0;
              out_q   <= bus.Req_Data;
              outv_q  <= 1'b1;
            end else begin
              state_q <= IN_WAIT_PRESS;
            end
          end
        end
        IN_WAIT_PRESS: begin
          if (press) begin
            rsp_q   <= {14'b0, bus.Switches};
            state_q <= IN_WAIT_RELEASE;
          end
        end
        IN_WAIT_RELEASE: begin
          if (release_ev) begin
            cnt_q   <= cnt_q + 8'd1;
            state_q <= DONE;
          end
        end
        OUT_HOLD: begin
          if (hold_q == HW'(OUT_HOLD_CYCLES - 1)) state_q <= DONE;
          else hold_q <= hold_q + HW'(1);
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.Rsp_Data    = rsp_q;
  assign bus.Out_Data    = out_q;
  assign bus.Out_Valid   = outv_q;
  assign bus.Input_Count = cnt_q;
  assign bus.Done        = (state_q == DONE);
  assign bus.Stall       = (state_q != IDLE) && (state_q != DONE);
endmodule

// File: tb/tb_io_sequencer.sv
// Randomized bench for io_sequencer against a cycle-level behavioural model
// of the debounced confirm key and the request lifecycle.
module tb_io_sequencer;
  localparam int D = 4;
  localparam int H = 2;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  io_sequencer_if bus();
  io_sequencer #(.DEBOUNCE_CYCLES(D), .OUT_HOLD_CYCLES(H)) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit rnd_sw  = 0;

  // model state
  int          cyc = 0;
  int          rawq[$];
  int          syncq[$];
  bit          m_deb;
  int          m_op;       // 0 none, 1 input, 2 output
  bit          m_pressed;
  int          m_acc, m_done, m_outv;
  logic [31:0] m_rsp, m_out;
  logic [7:0]  m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge();
    int  s;
    bit  all0, all1, press, rel, was_idle;
    cyc++;
    if (!Reset) begin
      rawq = '{1, 1};
      syncq.delete();
      m_deb = 1; m_op = 0; m_pressed = 0;
      m_acc = -10; m_done = -10; m_outv = -10;
      m_rsp = '0; m_out = '0; m_cnt = '0;
      return;
    end
    s = rawq.pop_front();
    rawq.push_back(int'(bus.Confirm_Raw));
    syncq.push_back(s);
    if (syncq.size() > D) void'(syncq.pop_front());
    all0 = (syncq.size() == D);
    all1 = (syncq.size() == D);
    foreach (syncq[i]) begin
      if (syncq[i] != 0) all0 = 0;
      if (syncq[i] != 1) all1 = 0;
    end
    press = m_deb && all0;
    rel   = !m_deb && all1;
    if (press) m_deb = 0;
    if (rel)   m_deb = 1;
    was_idle = (m_op == 0) && (m_done != cyc - 1);
    if (m_op == 1 && !m_pressed && press) begin
      m_rsp = {14'b0, bus.Switches};
      m_pressed = 1;
    end else if (m_op == 1 && m_pressed && rel) begin
      m_cnt++;
      m_op = 0; m_done = cyc;
    end else if (m_op == 2 && cyc - m_acc == H) begin
      m_op = 0; m_done = cyc;
    end
    if (was_idle && bus.Req) begin
      m_acc = cyc;
      if (bus.Req_Dir) begin
        m_op = 2; m_out = bus.Req_Data; m_outv = cyc;
      end else begin
        m_op = 1; m_pressed = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    model_edge();
    #1;
    chk("done",  bus.Done,        m_done == cyc);
    chk("stall", bus.Stall,       m_op != 0);
    chk("outv",  bus.Out_Valid,   m_outv == cyc);
    chk("outd",  bus.Out_Data,    m_out);
    chk("rsp",   bus.Rsp_Data,    m_rsp);
    chk("cnt",   bus.Input_Count, m_cnt);
    if (rnd_sw) bus.Switches = 18'($urandom);
  endtask

  task automatic wait_done(input int max, output int n_st, output int n_ov);
    bit seen;
    seen = 0; n_st = 0; n_ov = 0;
    for (int i = 0; i < max && !seen; i++) begin
      tick();
      if (bus.Stall)     n_st++;
      if (bus.Out_Valid) n_ov++;
      if (bus.Done)      seen = 1;
    end
    bus.Req = 1'b0;
    if (!seen) chk("timeout", {31'b0, seen}, 32'd1);
  endtask

  task automatic do_out(input logic [31:0] data, output int n_st, output int n_ov);
    bus.Req = 1'b1; bus.Req_Dir = 1'b1; bus.Req_Data = data;
    wait_done(H + 6, n_st, n_ov);
    bus.Req_Data = 32'($urandom);
  endtask

  task automatic do_in(input logic [17:0] sw, input int lowlen);
    int n_st, n_ov;
    bus.Req = 1'b1; bus.Req_Dir = 1'b0;
    tick();
    bus.Switches = sw;
    bus.Confirm_Raw = 1'b0;
    repeat (lowlen) tick();
    bus.Confirm_Raw = 1'b1;
    wait_done(3 * D + 12, n_st, n_ov);
  endtask

  initial begin
    int n_st, n_ov;
    bus.Req = 0; bus.Req_Dir = 0; bus.Req_Data = '0;
    bus.Confirm_Raw = 1; bus.Switches = '0;

    // reset
    repeat (3) tick();
    chk("rst_outd", bus.Out_Data, 32'h0);
    chk("rst_cnt",  bus.Input_Count, 32'h0);
    Reset = 1'b1;
    repeat (3) tick();
    chk("idle_stall", bus.Stall, 1'b0);

    // output op
    do_out(32'hDEADBEEF, n_st, n_ov);
    chk("out_data",  bus.Out_Data, 32'hDEADBEEF);
    chk("out_stall", n_st, H);
    chk("out_vcnt",  n_ov, 1);
    repeat (2) tick();

    // input op
    do_in(18'h2A5F3, 10);
    chk("in_rsp", bus.Rsp_Data, 32'h0002A5F3);
    chk("in_cnt", bus.Input_Count, 32'd1);
    repeat (3) tick();

    // bounce during IN_WAIT_PRESS
    bus.Req = 1'b1; bus.Req_Dir = 1'b0;
    tick();
    bus.Switches = 18'h3FFFF;
    for (int i = 0; i < 20; i++) begin
      bus.Confirm_Raw = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    bus.Confirm_Raw = 1'b1;
    repeat (D + 2) tick();
    chk("bnc_stall", bus.Stall, 1'b1);
    chk("bnc_rsp",   bus.Rsp_Data, 32'h0002A5F3);
    bus.Switches = 18'h01234;
    bus.Confirm_Raw = 1'b0;
    repeat (D + 4) tick();
    bus.Confirm_Raw = 1'b1;
    wait_done(3 * D + 12, n_st, n_ov);
    chk("bnc_rsp2", bus.Rsp_Data, 32'h00001234);
    chk("bnc_cnt",  bus.Input_Count, 32'd2);
    repeat (2) tick();

    // key held before the request
    bus.Confirm_Raw = 1'b0;
    repeat (10) tick();
    bus.Switches = 18'h3FFFF;
    bus.Req = 1'b1; bus.Req_Dir = 1'b0;
    repeat (10) tick();
    chk("held_rsp",   bus.Rsp_Data, 32'h00001234);
    chk("held_stall", bus.Stall, 1'b1);
    bus.Confirm_Raw = 1'b1;
    repeat (D + 4) tick();
    bus.Switches = 18'h15555;
    bus.Confirm_Raw = 1'b0;
    repeat (D + 4) tick();
    bus.Confirm_Raw = 1'b1;
    wait_done(3 * D + 12, n_st, n_ov);
    chk("held_rsp2", bus.Rsp_Data, 32'h00015555);
    repeat (2) tick();

    // randomized mix
    rnd_sw = 1;
    for (int op = 0; op < 40; op++) begin
      repeat ($urandom_range(0, 5)) begin
        bus.Confirm_Raw = 1'($urandom);
        tick();
      end
      bus.Confirm_Raw = 1'b1;
      repeat (D + 3) tick();
      if ($urandom_range(0, 1) == 1) begin
        do_out(32'($urandom), n_st, n_ov);
        chk("rnd_out_stall", n_st, H);
      end else begin
        bus.Req = 1'b1; bus.Req_Dir = 1'b0;
        tick();
        for (int b = 0; b < int'($urandom_range(0, 4)); b++) begin
          bus.Confirm_Raw = ~bus.Confirm_Raw;
          repeat ($urandom_range(1, D - 1)) tick();
        end
        bus.Confirm_Raw = 1'b0;
        repeat ($urandom_range(D, D + 6)) tick();
        bus.Confirm_Raw = 1'b1;
        wait_done(3 * D + 12, n_st, n_ov);
      end
    end
    rnd_sw = 0;

    // reset while waiting for release
    bus.Confirm_Raw = 1'b1;
    repeat (D + 3) tick();
    bus.Req = 1'b1; bus.Req_Dir = 1'b0;
    tick();
    bus.Req = 1'b0;
    bus.Confirm_Raw = 1'b0;
    repeat (D + 6) tick();
    chk("mid_stall", bus.Stall, 1'b1);
    Reset = 1'b0;
    tick();
    chk("mid_done", bus.Done, 1'b0);
    bus.Confirm_Raw = 1'b1;
    tick();
    Reset = 1'b1;
    repeat (D + 6) tick();
    chk("mid_cnt",  bus.Input_Count, 32'd0);
    chk("mid_idle", bus.Stall, 1'b0);

    // counter wrap
    for (int i = 0; i < 256; i++) begin
      do_in(18'($urandom), D + 1);
      if (i == 254) chk("cnt255", bus.Input_Count, 32'd255);
    end
    chk("cnt_wrap", bus.Input_Count, 32'd0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
